// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction prefetch queue.
// master = fetch/decode side, slave = the queue itself.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          fetch_valid;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_instr;
  logic          fetch_ready;
  logic          dec_valid;
  logic          dec_ready;
  logic [31:0]   dec_pc;
  logic [31:0]   dec_pc4;
  logic [31:0]   dec_instr;
  logic          dec_misaligned;
  logic [CW-1:0] count;

  modport master (
    output flush, fetch_valid, fetch_pc, fetch_instr, dec_ready,
    input  fetch_ready, dec_valid, dec_pc, dec_pc4, dec_instr, dec_misaligned, count
  );

  modport slave (
    input  flush, fetch_valid, fetch_pc, fetch_instr, dec_ready,
    output fetch_ready, dec_valid, dec_pc, dec_pc4, dec_instr, dec_misaligned, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO: first-word fall-through head, one-cycle flush on redirect.
// DEPTH must be a power of two >= 2 so the pointers wrap by natural overflow.
module fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input logic          clk,
  input logic          reset,
  fetch_queue_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic   full, empty, push, pop;
  entry_t head;
  logic [31:0] dec_pc;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // Acceptance depends only on registered occupancy, never on dec_ready.
  assign push  = bus.fetch_valid && !full;
  assign pop   = bus.dec_ready && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      mem_q[wptr_q] <= '{pc: bus.fetch_pc, instr: bus.fetch_instr};
    end
  end

  assign head = mem_q[rptr_q];

  always_comb begin
    dec_pc             = '0;
    bus.dec_instr      = NOP_INSTR;
    bus.dec_misaligned = 1'b0;
    if (!empty) begin
      dec_pc             = head.pc;
      bus.dec_instr      = head.instr;
      bus.dec_misaligned = (head.pc[1:0] != 2'b00);
    end
  end

  assign bus.dec_pc      = dec_pc;
  assign bus.dec_pc4     = dec_pc + 32'd4;
  assign bus.dec_valid   = !empty;
  assign bus.fetch_ready = !full;
  assign bus.count       = count_q;
endmodule
